// File: rtl/glip_loopback_fifo.sv
// ---------------------------------------------------------------------------
// glip_loopback_fifo
//
// Elastic loopback buffer between the GLIP backend's host->logic stream and
// its logic->host stream. Words accepted on the input side are stored in a
// small circular buffer and returned unmodified and in order on the output
// side. The block also reports the current occupancy, the peak occupancy
// since reset, and the number of words returned. Host-side loopback tests use
// these to exercise backpressure and read back buffer statistics.
//
// Ports
//   clk         single clock, all state changes on the rising edge
//   rst         asynchronous reset, active low (0 = reset)
//   in_data     word from the backend (fifo_in_data)
//   in_valid    in_data valid (fifo_in_valid)
//   in_ready    buffer can accept a word (fifo_in_ready)
//   out_data    head word towards the backend (fifo_out_data), FWFT
//   out_valid   out_data valid (fifo_out_valid)
//   out_ready   backend accepts the head word (fifo_out_ready)
//   level       current occupancy, 0..DEPTH
//   high_water  maximum level seen since reset
//   word_count  number of output handshakes since reset, wraps at 2^32
// ---------------------------------------------------------------------------
module glip_loopback_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LW-1:0]    level,
    output logic [LW-1:0]    high_water,
    output logic [31:0]      word_count
);

    // Pointer width; DEPTH is a power of two so pointers wrap on overflow.
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic [LW-1:0] level_next;
    logic [LW-1:0] high_water_reg;
    logic [LW-1:0] high_water_next;
    logic [31:0]   word_count_reg;

    logic push;
    logic pop;

    // Flow control depends only on the level register, never on the
    // opposite handshake input, so there is no combinational path from
    // in_valid to out_valid or from out_ready to in_ready.
    assign in_ready  = (level_reg != LW'(DEPTH));
    assign out_valid = (level_reg != '0);

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // First-word fall-through: head word is read combinationally.
    assign out_data = mem[rd_ptr_reg];

    assign level      = level_reg;
    assign high_water = high_water_reg;
    assign word_count = word_count_reg;

    always_comb begin
        level_next = level_reg;
        case ({push, pop})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_comb begin
        high_water_next = high_water_reg;
        if (level_next > high_water_reg) begin
            high_water_next = level_next;
        end
    end

    // Storage is deliberately not reset; the write is gated by rst so that
    // nothing is taken while reset is held, even though in_ready reads 1.
    always_ff @(posedge clk) begin
        if (push && rst) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            level_reg      <= '0;
            high_water_reg <= '0;
            word_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg     <= rd_ptr_reg + PW'(1);
                word_count_reg <= word_count_reg + 32'd1;
            end
            level_reg      <= level_next;
            high_water_reg <= high_water_next;
        end
    end

endmodule

// File: tb/tb_glip_loopback_fifo.sv
// ---------------------------------------------------------------------------
// tb_glip_loopback_fifo
//
// Self-checking bench for glip_loopback_fifo. A queue-based model tracks the
// buffered words, peak occupancy and returned-word count; each scenario task
// drives one cycle at a time through step() and compares the DUT against the
// model inline.
// ---------------------------------------------------------------------------
module tb_glip_loopback_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [LW-1:0]    level;
    logic [LW-1:0]    high_water;
    logic [31:0]      word_count;

    glip_loopback_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .level      (level),
        .high_water (high_water),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model
    logic [WIDTH-1:0] model_q[$];
    int               m_hw = 0;
    int               m_wc = 0;

    // Values captured by step() for the cycle just completed
    logic             o_in_ready, o_out_valid;
    logic [WIDTH-1:0] o_out_data;
    logic [LW-1:0]    o_level, o_hw;
    logic [31:0]      o_wc;
    logic             e_in_ready, e_out_valid;
    logic [WIDTH-1:0] e_head;
    logic [LW-1:0]    e_level, e_hw;
    logic [31:0]      e_wc;
    logic             did_push, did_pop;

    // One clock cycle: drive inputs, sample DUT before the edge, derive the
    // model's expectation, then advance the model across the rising edge.
    // Called and returns at a falling edge.
    task automatic step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        #1;
        o_in_ready  = in_ready;
        o_out_valid = out_valid;
        o_out_data  = out_data;
        o_level     = level;
        o_hw        = high_water;
        o_wc        = word_count;
        e_in_ready  = (model_q.size() < DEPTH);
        e_out_valid = (model_q.size() > 0);
        e_head      = e_out_valid ? model_q[0] : '0;
        e_level     = LW'(model_q.size());
        e_hw        = LW'(m_hw);
        e_wc        = 32'(m_wc);
        did_push    = iv && e_in_ready;
        did_pop     = ordy && e_out_valid;
        @(posedge clk);
        if (did_pop) begin
            void'(model_q.pop_front());
            m_wc++;
        end
        if (did_push) model_q.push_back(id);
        if (model_q.size() > m_hw) m_hw = model_q.size();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        total++; if (level !== '0) begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (high_water !== '0) begin bad++; $display("FAIL reset_high_water got=%0d want=0", high_water); end
        total++; if (word_count !== 32'd0) begin bad++; $display("FAIL reset_word_count got=%0d want=0", word_count); end
        @(negedge clk);
        rst = 1'b1;
        model_q.delete(); m_hw = 0; m_wc = 0;
        $display("test_reset: done");
    endtask

    task automatic test_stream();
        for (int i = 0; i < 6; i++) begin
            step(i < 3, 16'(i + 1), 1'b1);
            total++; if (o_out_valid !== e_out_valid) begin bad++; $display("FAIL stream_valid cyc=%0d got=%0b want=%0b", i, o_out_valid, e_out_valid); end
            total++; if (o_level !== e_level) begin bad++; $display("FAIL stream_level cyc=%0d got=%0d want=%0d", i, o_level, e_level); end
            if (did_pop) begin
                total++; if (o_out_data !== e_head) begin bad++; $display("FAIL stream_data cyc=%0d got=%h want=%h", i, o_out_data, e_head); end
            end
            $display("stream cyc=%0d push=%0b pop=%0b data=%h", i, did_push, did_pop, o_out_data);
        end
        // Each word appears exactly one cycle after its push
        total++; if (word_count !== 32'd3) begin bad++; $display("FAIL stream_word_count got=%0d want=3", word_count); end
        total++; if (high_water !== LW'(1)) begin bad++; $display("FAIL stream_high_water got=%0d want=1", high_water); end
    endtask

    task automatic test_full();
        int idx = 0;
        int cyc = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 16'h0100 + 16'(i), 1'b0);
            if (did_push) idx++;
            total++; if (o_in_ready !== e_in_ready) begin bad++; $display("FAIL full_in_ready cyc=%0d got=%0b want=%0b", i, o_in_ready, e_in_ready); end
            $display("full cyc=%0d word=%h accepted=%0b level=%0d", i, 16'h0100 + 16'(i), did_push, o_level);
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL full_held_off got=%0b want=0", in_ready); end
        total++; if (level !== LW'(8)) begin bad++; $display("FAIL full_level got=%0d want=8", level); end
        // Release the output; keep offering 0x0108 until taken, then drain
        while ((idx < 9 || model_q.size() > 0) && cyc < 100) begin
            step(idx < 9, 16'h0100 + 16'(idx), 1'b1);
            if (did_push) idx++;
            if (did_pop) begin
                total++; if (o_out_data !== e_head) begin bad++; $display("FAIL full_data got=%h want=%h", o_out_data, e_head); end
                $display("full drain data=%h", o_out_data);
            end
            cyc++;
        end
        total++; if (cyc >= 100) begin bad++; $display("FAIL full_drain_timeout got=%0d want<100", cyc); end
        total++; if (high_water !== LW'(8)) begin bad++; $display("FAIL full_high_water got=%0d want=8", high_water); end
    endtask

    task automatic test_back_to_back();
        int wc0;
        for (int i = 0; i < 4; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0);
        wc0 = m_wc;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h0210 + 16'(i), 1'b1);
            total++; if (o_level !== LW'(4)) begin bad++; $display("FAIL b2b_level cyc=%0d got=%0d want=4", i, o_level); end
            total++; if (o_out_data !== e_head) begin bad++; $display("FAIL b2b_data cyc=%0d got=%h want=%h", i, o_out_data, e_head); end
            $display("b2b cyc=%0d in=%h out=%h", i, 16'h0210 + 16'(i), o_out_data);
        end
        total++; if (word_count !== 32'(wc0 + 20)) begin bad++; $display("FAIL b2b_word_count got=%0d want=%0d", word_count, wc0 + 20); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
            total++; if (o_out_data !== e_head) begin bad++; $display("FAIL b2b_drain cyc=%0d got=%h want=%h", i, o_out_data, e_head); end
        end
    endtask

    task automatic test_random();
        int next_word = 0;
        int popped    = 0;
        int cyc       = 0;
        int wc0       = m_wc;
        while ((next_word < 1000 || model_q.size() > 0) && cyc < 20000) begin
            step(next_word < 1000 && $urandom_range(0, 99) < 60, 16'(next_word),
                 $urandom_range(0, 99) < 55);
            if (did_push) next_word++;
            total++;
            if (o_in_ready !== e_in_ready || o_out_valid !== e_out_valid || o_level !== e_level ||
                o_hw !== e_hw || o_wc !== e_wc) begin
                bad++;
                $display("FAIL rand_state cyc=%0d got=rdy%0b vld%0b lvl%0d hw%0d wc%0d want=rdy%0b vld%0b lvl%0d hw%0d wc%0d",
                         cyc, o_in_ready, o_out_valid, o_level, o_hw, o_wc,
                         e_in_ready, e_out_valid, e_level, e_hw, e_wc);
            end
            if (did_pop) begin
                popped++;
                total++; if (o_out_data !== e_head) begin bad++; $display("FAIL rand_data cyc=%0d got=%h want=%h", cyc, o_out_data, e_head); end
            end
            total++; if (o_level > LW'(DEPTH)) begin bad++; $display("FAIL rand_level_bound got=%0d want<=8", o_level); end
            cyc++;
        end
        $display("random cycles=%0d pushed=%0d popped=%0d", cyc, next_word, popped);
        total++; if (cyc >= 20000) begin bad++; $display("FAIL rand_timeout got=%0d want<20000", cyc); end
        total++; if (level !== '0) begin bad++; $display("FAIL rand_final_level got=%0d want=0", level); end
        total++; if (word_count !== 32'(wc0 + 1000)) begin bad++; $display("FAIL rand_word_count got=%0d want=%0d", word_count, wc0 + 1000); end
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 5; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0);
        total++; if (level !== LW'(5)) begin bad++; $display("FAIL mreset_pre_level got=%0d want=5", level); end
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mreset_out_valid got=%0b want=0", out_valid); end
        total++; if (level !== '0) begin bad++; $display("FAIL mreset_level got=%0d want=0", level); end
        total++; if (high_water !== '0) begin bad++; $display("FAIL mreset_high_water got=%0d want=0", high_water); end
        total++; if (word_count !== 32'd0) begin bad++; $display("FAIL mreset_word_count got=%0d want=0", word_count); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL mreset_in_ready got=%0b want=1", in_ready); end
        // Offer a word across an edge while reset is held; it must be ignored
        in_valid = 1'b1; in_data = 16'hDEAD; out_ready = 1'b0;
        @(posedge clk); #1;
        total++; if (level !== '0) begin bad++; $display("FAIL mreset_no_push got=%0d want=0", level); end
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        model_q.delete(); m_hw = 0; m_wc = 0;
        step(1'b1, 16'hBEEF, 1'b0);
        step(1'b0, '0, 1'b1);
        total++; if (o_out_valid !== 1'b1) begin bad++; $display("FAIL mreset_beef_valid got=%0b want=1", o_out_valid); end
        total++; if (o_out_data !== 16'hBEEF) begin bad++; $display("FAIL mreset_beef_data got=%h want=beef", o_out_data); end
        total++; if (level !== '0) begin bad++; $display("FAIL mreset_final_level got=%0d want=0", level); end
        $display("mid_reset first word out=%h", o_out_data);
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_back_to_back();
        test_random();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
